// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: none (declarations only); backpressure: n/a.
package fetch_pkg;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0;
    localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO of {pc, inst} entries with flush; head is read combinationally.
// Latency: an entry written at posedge N is the head after N. Backpressure: caller must not enq when full without deq.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     enq_i,
    input  fetch_entry_t             enq_dat_i,
    input  logic                     deq_i,
    output fetch_entry_t             head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq_i) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PTR_W{1'b0}}, enq_i} - {{PTR_W{1'b0}}, deq_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (enq_i && !flush_i) mem_q[wr_ptr_q] <= enq_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
endmodule

// File: rtl/fetch_unit.sv
// PC owner driving the instruction ROM; queues {pc, inst} for decode. Optional macro FETCH_ALIGN_CHECK_EN.
// Latency: fetch at posedge N visible on out_* after N. Backpressure: PC stalls when queue full; redirect flushes.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);
    logic [31:0]  pc_q, pc_d;
    logic         rom_ce_q, rom_ce_d;
    logic         misalign_q, misalign_d;
    logic         fetch_fire, deq_fire;
    logic         q_full, q_empty;
    logic [$clog2(QUEUE_DEPTH):0] q_count;
    fetch_entry_t enq_dat, head_dat;

    assign out_valid  = !q_empty;
    assign deq_fire   = out_valid && out_ready && !redirect_valid;
    assign fetch_fire = rom_ce_q && !redirect_valid && (!q_full || deq_fire);
    assign enq_dat    = '{pc: pc_q, inst: rom_inst};

    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            pc_d = align_word(redirect_pc);
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_d = (redirect_pc[1:0] != 2'b00);
`endif
        end else if (fetch_fire) begin
            pc_d = pc_q + PC_STEP;
        end
        // A misaligned target parks fetch until an aligned redirect arrives.
        rom_ce_d = !misalign_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            rom_ce_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rom_ce_q   <= rom_ce_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk_i      (clk),
        .rst_ni     (rst),
        .flush_i    (redirect_valid),
        .enq_i      (fetch_fire),
        .enq_dat_i  (enq_dat),
        .deq_i      (deq_fire),
        .head_dat_o (head_dat),
        .count_o    (q_count),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    assign rom_ce   = rom_ce_q;
    assign rom_addr = pc_q;
    assign out_pc   = out_valid ? head_dat.pc   : 32'h0;
    assign out_inst = out_valid ? head_dat.inst : NOP_INST;

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_misalign = misalign_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequence, then random traffic vs a queue model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        mis_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_ce         (rom_ce),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misalign (mis_o)
`endif
    );
`ifndef FETCH_ALIGN_CHECK_EN
    assign mis_o = 1'b0;
`endif

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h3401_1100;
            32'h4:   return 32'h3402_0020;
            32'h8:   return 32'h3403_ff00;
            32'hC:   return 32'h3404_ffff;
            default: return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign rom_inst = rom_word(rom_addr);

    // Reference model: a queue of {pc, inst} plus PC and enable flags.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc  = RESET_PC;
    bit          m_ce  = 1'b0;
    bit          m_mis = 1'b0;

    task automatic model_edge(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit take, fetch;
        if (!r) begin
            mq.delete();
            m_pc  = RESET_PC;
            m_ce  = 1'b0;
            m_mis = 1'b0;
        end else if (rv) begin
            mq.delete();
            m_pc = rpc & ~32'h3;
`ifdef FETCH_ALIGN_CHECK_EN
            m_mis = (rpc % 4) != 0;
`endif
            m_ce = !m_mis;
        end else begin
            take  = (mq.size() > 0) && rdy;
            fetch = m_ce && (mq.size() < DEPTH || take);
            if (take) void'(mq.pop_front());
            if (fetch) begin
                mq.push_back({m_pc, rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            m_ce = !m_mis;
        end
    endtask

    task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        model_edge(r, rv, rpc, rdy);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input int cyc);
        check($sformatf("rnd%0d valid", cyc), {31'b0, out_valid}, {31'b0, mq.size() != 0});
        check($sformatf("rnd%0d pc", cyc), out_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
        check($sformatf("rnd%0d inst", cyc), out_inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
        check($sformatf("rnd%0d addr", cyc), rom_addr, m_pc);
        check($sformatf("rnd%0d ce", cyc), {31'b0, rom_ce}, {31'b0, m_ce});
`ifdef FETCH_ALIGN_CHECK_EN
        check($sformatf("rnd%0d mis", cyc), {31'b0, mis_o}, {31'b0, m_mis});
`endif
    endtask

    typedef struct {
        bit          r, rv, rdy;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc, ei, ea;
        bit          ece, emis;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy,
                       input bit ev, input logic [31:0] epc, input logic [31:0] ea,
                       input bit ece, input bit emis);
        vec_t v;
        v.r = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.ei = ev ? rom_word(epc) : 32'h0;
        v.ea = ea; v.ece = ece; v.emis = emis;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        //    r  rv rpc            rdy ev epc            addr           ce mis
        add(0, 0, 32'h0,          1,  0, 32'h0,          32'h0,          0, 0);
        add(1, 0, 32'h0,          1,  0, 32'h0,          32'h0,          1, 0);
        add(1, 0, 32'h0,          1,  1, 32'h0,          32'h4,          1, 0);
        add(1, 0, 32'h0,          1,  1, 32'h4,          32'h8,          1, 0);
        add(1, 0, 32'h0,          1,  1, 32'h8,          32'hC,          1, 0);
        add(1, 0, 32'h0,          1,  1, 32'hC,          32'h10,         1, 0);
        add(0, 0, 32'h0,          0,  0, 32'h0,          32'h0,          0, 0);
        add(1, 0, 32'h0,          0,  0, 32'h0,          32'h0,          1, 0);
        add(1, 0, 32'h0,          0,  1, 32'h0,          32'h4,          1, 0);
        add(1, 0, 32'h0,          0,  1, 32'h0,          32'h8,          1, 0);
        add(1, 0, 32'h0,          0,  1, 32'h0,          32'h8,          1, 0);
        add(1, 0, 32'h0,          0,  1, 32'h0,          32'h8,          1, 0);
        add(1, 0, 32'h0,          1,  1, 32'h4,          32'hC,          1, 0);
        add(1, 0, 32'h0,          1,  1, 32'h8,          32'h10,         1, 0);
        add(1, 1, 32'h40,         1,  0, 32'h0,          32'h40,         1, 0);
        add(1, 0, 32'h0,          1,  1, 32'h40,         32'h44,         1, 0);
        add(1, 1, 32'hFFFF_FFFC,  0,  0, 32'h0,          32'hFFFF_FFFC,  1, 0);
        add(1, 0, 32'h0,          0,  1, 32'hFFFF_FFFC,  32'h0,          1, 0);
        add(0, 0, 32'h0,          1,  0, 32'h0,          RESET_PC,       0, 0);
        add(1, 0, 32'h0,          1,  0, 32'h0,          32'h0,          1, 0);
        add(1, 1, 32'h100,        1,  0, 32'h0,          32'h100,        1, 0);
        add(1, 1, 32'h200,        1,  0, 32'h0,          32'h200,        1, 0);
        add(1, 0, 32'h0,          1,  1, 32'h200,        32'h204,        1, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        add(1, 1, 32'h42,         1,  0, 32'h0,          32'h40,         0, 1);
        add(1, 0, 32'h0,          1,  0, 32'h0,          32'h40,         0, 1);
        add(1, 1, 32'h44,         1,  0, 32'h0,          32'h44,         1, 0);
        add(1, 0, 32'h0,          1,  1, 32'h44,         32'h48,         1, 0);
`else
        add(1, 1, 32'h42,         1,  0, 32'h0,          32'h40,         1, 0);
        add(1, 0, 32'h0,          1,  1, 32'h40,         32'h44,         1, 0);
`endif

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            check($sformatf("vec%0d valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
            check($sformatf("vec%0d pc", i), out_pc, vecs[i].epc);
            check($sformatf("vec%0d inst", i), out_inst, vecs[i].ei);
            check($sformatf("vec%0d addr", i), rom_addr, vecs[i].ea);
            check($sformatf("vec%0d ce", i), {31'b0, rom_ce}, {31'b0, vecs[i].ece});
`ifdef FETCH_ALIGN_CHECK_EN
            check($sformatf("vec%0d mis", i), {31'b0, mis_o}, {31'b0, vecs[i].emis});
`endif
        end

        // Stall until full, then drain: head must hold, then stream in order without gaps.
        step(0, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 32'h0, 0);
            check($sformatf("hold%0d pc", k), out_pc, 32'h0);
            check($sformatf("hold%0d inst", k), out_inst, rom_word(32'h0));
        end
        for (int j = 0; j < 6; j++) begin
            logic [31:0] epc;
            epc = 32'(4 * (j + 1));
            step(1, 0, 32'h0, 1);
            check($sformatf("drain%0d pc", j), out_pc, epc);
            check($sformatf("drain%0d inst", j), out_inst, rom_word(epc));
        end

        // Random traffic against the queue model.
        step(0, 0, 32'h0, 1);
        for (int c = 0; c < 800; c++) begin
            bit          r, rv, rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 59) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 5))
                0:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                1:       rpc = $urandom;
                default: rpc = $urandom & 32'h0000_FFFC;
            endcase
            step(r, rv, rpc, rdy);
            check_model(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
